// File: rtl/mult_rr_arbiter.sv
// Round-robin front end for one shared W x W unsigned multiplier.
// One request is accepted at a time. Its operands are latched on the grant edge.
// The product is registered one cycle later and offered on a valid/ready
// response channel together with the owning requester's index.
module mult_rr_arbiter #(
    parameter int N   = 4,
    parameter int W   = 4,
    parameter int IDW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [N*W-1:0]     a_in,
    input  logic [N*W-1:0]     b_in,
    output logic [N-1:0]       gnt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [2*W-1:0]     rsp_product,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] idx_reg;
    logic [IDW-1:0] rsp_id_reg;
    logic [W-1:0]   op_a_reg, op_b_reg;
    logic [2*W-1:0] product_reg;

    logic [IDW-1:0] win_idx;
    logic           any_req;
    logic           rsp_fire;
    int             best_i, best_dist, dist_i;

    logic [W-1:0]   a_arr [N];
    logic [W-1:0]   b_arr [N];

    // Unpack the flat operand buses into per-requester slices.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign a_arr[gi] = a_in[gi*W +: W];
            assign b_arr[gi] = b_in[gi*W +: W];
        end
    endgenerate

    // Winner is the requester with the smallest circular distance above the pointer.
    always_comb begin
        best_i    = 0;
        best_dist = N;
        dist_i    = 0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                dist_i = (i >= int'(ptr_reg)) ? (i - int'(ptr_reg))
                                              : (i + N - int'(ptr_reg));
                if (dist_i < best_dist) begin
                    best_dist = dist_i;
                    best_i    = i;
                end
            end
        end
        win_idx = IDW'(best_i);
        any_req = |req;
    end

    // One-hot grant, only while idle; forced low while reset is held.
    always_comb begin
        gnt = '0;
        if (rst_n && (state_reg == IDLE) && any_req) begin
            gnt[win_idx] = 1'b1;
        end
    end

    assign rsp_fire = (state_reg == RESP) && rsp_ready;

    // Next-state logic: grant -> multiply -> hold response until accepted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req)  state_next = MUL;
            MUL:                   state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture, product register and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg     <= '0;
            idx_reg     <= '0;
            rsp_id_reg  <= '0;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        op_a_reg <= a_arr[win_idx];
                        op_b_reg <= b_arr[win_idx];
                        idx_reg  <= win_idx;
                    end
                end
                MUL: begin
                    // Both operands are widened first so the product keeps all 2W bits.
                    product_reg <= (2*W)'(op_a_reg) * (2*W)'(op_b_reg);
                    rsp_id_reg  <= idx_reg;
                end
                RESP: begin
                    // The pointer advances only when a response completes.
                    if (rsp_ready) begin
                        ptr_reg <= (idx_reg == IDW'(N-1)) ? '0 : idx_reg + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid   = (state_reg == RESP);
    assign busy        = (state_reg != IDLE);
    assign rsp_id      = rsp_id_reg;
    assign rsp_product = product_reg;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter (N=4, W=4). Inputs are driven 1 ns
// after the rising edge. Outputs are checked 1 ns after the inputs settle.
module tb_mult_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [2*W-1:0] rsp_product;
    logic           busy;

    int checks = 0;
    int errors = 0;

    mult_rr_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .a_in        (a_in),
        .b_in        (b_in),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected grant order and products for the round-robin phase.
    logic [3:0] rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         rr_id   [5] = '{0, 1, 2, 3, 0};
    int         rr_prod [5] = '{6, 20, 42, 210, 6};

    initial begin
        // Reset with every requester active.
        rst_n     = 1'b0;
        req       = 4'b1111;
        a_in      = '0;
        b_in      = '0;
        rsp_ready = 1'b1;
        #1;
        chk("reset_gnt", gnt, 0);
        chk("reset_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_id", rsp_id, 0);
        chk("reset_product", rsp_product, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("release_gnt", gnt, 4'b0001);
        cyc();                                  // MUL
        req = 4'b0000;
        #1;
        chk("first_mul_busy", busy, 1);
        chk("first_mul_gnt", gnt, 0);
        cyc();                                  // RESP
        chk("first_resp_valid", rsp_valid, 1);
        chk("first_resp_product", rsp_product, 0);
        $display("txn id=%0d product=%0d", rsp_id, rsp_product);
        cyc();                                  // IDLE, pointer = 1

        // Single request from requester 2: 12 * 13.
        req  = 4'b0100;
        a_in = {4'd0, 4'd12, 4'd0, 4'd0};
        b_in = {4'd0, 4'd13, 4'd0, 4'd0};
        #1;
        chk("single_gnt", gnt, 4'b0100);
        cyc();                                  // MUL, req still held
        chk("single_gnt_mul", gnt, 0);
        chk("single_valid_mul", rsp_valid, 0);
        req = 4'b0000;
        cyc();                                  // RESP
        chk("single_valid", rsp_valid, 1);
        chk("single_id", rsp_id, 2);
        chk("single_product", rsp_product, 156);
        $display("txn id=%0d product=%0d", rsp_id, rsp_product);
        cyc();                                  // IDLE, pointer = 3
        chk("single_valid_drop", rsp_valid, 0);
        chk("single_busy_drop", busy, 0);

        // Wrap-around from pointer 3 with backpressure on 10 * 11.
        req  = 4'b1001;
        a_in = {4'd10, 4'd0, 4'd0, 4'd2};
        b_in = {4'd11, 4'd0, 4'd0, 4'd3};
        #1;
        chk("wrap_gnt", gnt, 4'b1000);
        cyc();                                  // MUL
        req       = 4'b0001;
        rsp_ready = 1'b0;
        cyc();                                  // RESP
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_product", rsp_product, 110);
            chk("bp_id", rsp_id, 3);
            chk("bp_gnt", gnt, 0);
            cyc();
        end
        chk("bp_still_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        $display("txn id=%0d product=%0d", rsp_id, rsp_product);
        cyc();                                  // IDLE, pointer = 0
        chk("bp_valid_drop", rsp_valid, 0);

        // Round-robin with all four requesters held.
        req  = 4'b1111;
        a_in = {4'd14, 4'd6, 4'd4, 4'd2};
        b_in = {4'd15, 4'd7, 4'd5, 4'd3};
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_gnt", gnt, rr_gnt[k]);
            cyc();                              // MUL
            if (k == 4) req = 4'b0000;
            #1;
            chk("rr_gnt_mul", gnt, 0);
            cyc();                              // RESP
            chk("rr_gnt_resp", gnt, 0);
            chk("rr_valid", rsp_valid, 1);
            chk("rr_id", rsp_id, rr_id[k]);
            chk("rr_product", rsp_product, rr_prod[k]);
            $display("txn id=%0d product=%0d", rsp_id, rsp_product);
            cyc();                              // IDLE
        end
        // Pointer is now 1.

        // Asynchronous reset during MUL.
        req  = 4'b0010;
        a_in = {4'd0, 4'd0, 4'd9, 4'd0};
        b_in = {4'd0, 4'd0, 4'd9, 4'd0};
        #1;
        chk("areset_pre_gnt", gnt, 4'b0010);
        cyc();                                  // MUL
        req = 4'b0000;
        #2;
        chk("areset_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("areset_busy", busy, 0);
        chk("areset_valid", rsp_valid, 0);
        chk("areset_gnt", gnt, 0);
        chk("areset_product", rsp_product, 0);
        chk("areset_id", rsp_id, 0);
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("areset_no_stale", rsp_valid, 0);
        end
        req = 4'b1111;
        #1;
        chk("areset_ptr_zero", gnt, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
